// File: rtl/vc_fifo_pkg.sv
// Shared sizing helpers for the virtual-channel FIFO and the router VC logic that imports them.
// Pure functions only: no latency and no flow control.
package vc_fifo_pkg;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

   // A single channel still needs a one-bit channel id on the ports.
   function automatic int vc_id_width(input int vc_num);
      return (clog2(vc_num) < 1) ? 1 : clog2(vc_num);
   endfunction

   function automatic int ptr_width(input int depth_width);
      return depth_width + 1;
   endfunction

endpackage

// File: rtl/vc_fifo_bank.sv
// One virtual channel: storage, wrap-bit pointer pair, full/empty/count, and almost flags under VC_FIFO_ALMOST_EN.
// Writes and reads arrive pre-accepted from the top; read data is combinational; no internal backpressure.
module vc_fifo_bank
   import vc_fifo_pkg::*;
#(
   parameter int DATA_WIDTH       = 8,
   parameter int FIFO_DEPTH_WIDTH = 2
`ifdef VC_FIFO_ALMOST_EN
   ,
   parameter int ALMOST_FULL_LEVEL  = (1 << FIFO_DEPTH_WIDTH) - 1,
   parameter int ALMOST_EMPTY_LEVEL = 1
`endif
) (
   input  logic                                 clk_i,
   input  logic                                 rst_ni,
   input  logic                                 i_wr_en,
   input  logic [DATA_WIDTH-1:0]                i_wr_data,
   input  logic                                 i_rd_en,
   output logic [DATA_WIDTH-1:0]                o_rd_data,
   output logic                                 o_full,
   output logic                                 o_empty,
`ifdef VC_FIFO_ALMOST_EN
   output logic                                 o_almost_full,
   output logic                                 o_almost_empty,
`endif
   output logic [ptr_width(FIFO_DEPTH_WIDTH)-1:0] o_count
);

   localparam int DEPTH = 1 << FIFO_DEPTH_WIDTH;
   localparam int PW    = ptr_width(FIFO_DEPTH_WIDTH);
   localparam int AW    = (FIFO_DEPTH_WIDTH > 0) ? FIFO_DEPTH_WIDTH : 1;
   localparam logic [PW-1:0] ADDR_MASK = PW'(DEPTH - 1);
   localparam logic [PW-1:0] WRAP_ONLY = PW'(DEPTH);

   logic [PW-1:0]         r_wr_ptr;
   logic [PW-1:0]         r_rd_ptr;
   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]         w_wr_addr;
   logic [AW-1:0]         w_rd_addr;
   logic [PW-1:0]         w_count;

   // Masking instead of slicing keeps the single-entry (width 0) case legal.
   assign w_wr_addr = AW'(r_wr_ptr & ADDR_MASK);
   assign w_rd_addr = AW'(r_rd_ptr & ADDR_MASK);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (i_wr_en) r_wr_ptr <= r_wr_ptr + PW'(1);
         if (i_rd_en) r_rd_ptr <= r_rd_ptr + PW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (i_wr_en) r_mem[w_wr_addr] <= i_wr_data;
   end

   assign w_count   = r_wr_ptr - r_rd_ptr;
   assign o_count   = w_count;
   assign o_empty   = (r_wr_ptr == r_rd_ptr);
   assign o_full    = ((r_wr_ptr ^ r_rd_ptr) == WRAP_ONLY);
   assign o_rd_data = r_mem[w_rd_addr];

`ifdef VC_FIFO_ALMOST_EN
   localparam logic [PW-1:0] AF_LVL = PW'(ALMOST_FULL_LEVEL);
   localparam logic [PW-1:0] AE_LVL = PW'(ALMOST_EMPTY_LEVEL);
   assign o_almost_full  = (w_count >= AF_LVL);
   assign o_almost_empty = (w_count <= AE_LVL);
`endif

endmodule

// File: rtl/vc_fifo.sv
// Multi-channel circular FIFO: shared write/read ports over VC_NUM banks; optional almost flags under VC_FIFO_ALMOST_EN.
// Read data registered one cycle; rejected requests (full/empty/bad id) raise one-cycle overflow/underflow pulses.
module vc_fifo
   import vc_fifo_pkg::*;
#(
   parameter int DATA_WIDTH       = 8,
   parameter int FIFO_DEPTH_WIDTH = 2,
`ifdef VC_FIFO_ALMOST_EN
   parameter int ALMOST_FULL_LEVEL  = (1 << FIFO_DEPTH_WIDTH) - 1,
   parameter int ALMOST_EMPTY_LEVEL = 1,
`endif
   parameter int VC_NUM           = 2
) (
   input  logic                                        clk_i,
   input  logic                                        rst_ni,
   input  logic                                        wr_en_i,
   input  logic [vc_id_width(VC_NUM)-1:0]              wr_vc_i,
   input  logic [DATA_WIDTH-1:0]                       data_i,
   input  logic                                        rd_en_i,
   input  logic [vc_id_width(VC_NUM)-1:0]              rd_vc_i,
   output logic [DATA_WIDTH-1:0]                       data_o,
   output logic                                        valid_o,
   output logic [vc_id_width(VC_NUM)-1:0]              rd_vc_o,
   output logic [VC_NUM-1:0]                           full_o,
   output logic [VC_NUM-1:0]                           empty_o,
   output logic [VC_NUM*ptr_width(FIFO_DEPTH_WIDTH)-1:0] count_o,
`ifdef VC_FIFO_ALMOST_EN
   output logic [VC_NUM-1:0]                           almost_full_o,
   output logic [VC_NUM-1:0]                           almost_empty_o,
`endif
   output logic                                        overflow_o,
   output logic                                        underflow_o
);

   localparam int VCW = vc_id_width(VC_NUM);
   localparam int PW  = ptr_width(FIFO_DEPTH_WIDTH);

   logic [VC_NUM-1:0]     w_wr_sel;
   logic [VC_NUM-1:0]     w_rd_sel;
   logic [VC_NUM-1:0]     w_wr_acc;
   logic [VC_NUM-1:0]     w_rd_acc;
   logic [VC_NUM-1:0]     w_full;
   logic [VC_NUM-1:0]     w_empty;
   logic [DATA_WIDTH-1:0] w_bank_data [VC_NUM];
   logic [DATA_WIDTH-1:0] w_rd_data;
   logic                  w_rd_ok;
   logic                  w_wr_ok;

   logic [DATA_WIDTH-1:0] r_data;
   logic                  r_valid;
   logic [VCW-1:0]        r_rd_vc;
   logic                  r_overflow;
   logic                  r_underflow;

   // Ids at or above VC_NUM match no select bit, so they fall out as rejects.
   for (genvar v = 0; v < VC_NUM; v++) begin : g_vc
      assign w_wr_sel[v] = wr_en_i && (wr_vc_i == VCW'(v));
      assign w_rd_sel[v] = rd_en_i && (rd_vc_i == VCW'(v));
      assign w_rd_acc[v] = w_rd_sel[v] && !w_empty[v];
      assign w_wr_acc[v] = w_wr_sel[v] && (!w_full[v] || w_rd_acc[v]);

      vc_fifo_bank #(
         .DATA_WIDTH         (DATA_WIDTH),
         .FIFO_DEPTH_WIDTH   (FIFO_DEPTH_WIDTH)
`ifdef VC_FIFO_ALMOST_EN
         ,
         .ALMOST_FULL_LEVEL  (ALMOST_FULL_LEVEL),
         .ALMOST_EMPTY_LEVEL (ALMOST_EMPTY_LEVEL)
`endif
      ) u_bank (
         .clk_i          (clk_i),
         .rst_ni         (rst_ni),
         .i_wr_en        (w_wr_acc[v]),
         .i_wr_data      (data_i),
         .i_rd_en        (w_rd_acc[v]),
         .o_rd_data      (w_bank_data[v]),
         .o_full         (w_full[v]),
         .o_empty        (w_empty[v]),
`ifdef VC_FIFO_ALMOST_EN
         .o_almost_full  (almost_full_o[v]),
         .o_almost_empty (almost_empty_o[v]),
`endif
         .o_count        (count_o[v*PW +: PW])
      );
   end

   always_comb begin
      w_rd_data = '0;
      for (int v = 0; v < VC_NUM; v++) begin
         if (w_rd_sel[v]) w_rd_data = w_bank_data[v];
      end
   end

   assign w_rd_ok = |w_rd_acc;
   assign w_wr_ok = |w_wr_acc;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_data      <= '0;
         r_valid     <= 1'b0;
         r_rd_vc     <= '0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         r_valid     <= w_rd_ok;
         r_overflow  <= wr_en_i && !w_wr_ok;
         r_underflow <= rd_en_i && !w_rd_ok;
         if (w_rd_ok) begin
            r_data  <= w_rd_data;
            r_rd_vc <= rd_vc_i;
         end
      end
   end

   assign data_o      = r_data;
   assign valid_o     = r_valid;
   assign rd_vc_o     = r_rd_vc;
   assign full_o      = w_full;
   assign empty_o     = w_empty;
   assign overflow_o  = r_overflow;
   assign underflow_o = r_underflow;

endmodule

// File: doc/vc_fifo.md
# vc_fifo

Multi-channel circular FIFO for router input ports. It holds VC_NUM independent queues (virtual channels), each 2**FIFO_DEPTH_WIDTH entries deep, behind one shared write port and one shared read port. Every queue reports per-channel full/empty/occupancy, so the VC allocator and credit logic can run without shadow counters. Unlike the single-queue fifo, every slot is usable, and a write to a full queue succeeds when the same queue is read in the same cycle.

## Interface
- DATA_WIDTH, 8, flit width in bits
- FIFO_DEPTH_WIDTH, 2, log2 of per-channel depth (depth D = 2**FIFO_DEPTH_WIDTH, minimum 1)
- VC_NUM, 2, number of channels (minimum 1; any value, not only powers of two)
- clk_i  input  1  clock, rising edge
- rst_ni  input  1  asynchronous, active-low reset
- wr_en_i  input  1  write request
- wr_vc_i  input  VC_ID_WIDTH  target channel of the write
- data_i  input  DATA_WIDTH  write data
- rd_en_i  input  1  read request
- rd_vc_i  input  VC_ID_WIDTH  source channel of the read
- data_o  output  DATA_WIDTH  registered read data
- valid_o  output  1  data_o carries a flit popped on the previous edge
- rd_vc_o  output  VC_ID_WIDTH  channel data_o came from
- full_o  output  VC_NUM  bit v: channel v holds D entries
- empty_o  output  VC_NUM  bit v: channel v holds 0 entries
- count_o  output  VC_NUM*(FIFO_DEPTH_WIDTH+1)  per-channel occupancy; channel v occupies slice [v*(W+1) +: W+1], where W = FIFO_DEPTH_WIDTH
- overflow_o  output  1  one-cycle pulse: a write was rejected on the previous edge
- underflow_o  output  1  one-cycle pulse: a read was rejected on the previous edge

## Operation
- Each channel has a read pointer and a write pointer, each FIFO_DEPTH_WIDTH+1 bits wide; the MSB is the wrap bit.
  - empty: pointers are equal.
  - full: low bits are equal and MSBs differ.
  - count = wr_ptr - rd_ptr, computed modulo 2**(W+1).
- Read acceptance: rd_en_i, rd_vc_i < VC_NUM, and the channel is not empty.
  - Accepted: data_o <= entry at rd_ptr; rd_vc_o <= rd_vc_i; valid_o <= 1; rd_ptr increments.
  - Rejected: underflow_o <= 1; valid_o <= 0; data_o and rd_vc_o hold.
- Write acceptance: wr_en_i, wr_vc_i < VC_NUM, and either the channel is not full or a read of the same channel is accepted in the same cycle.
  - Accepted: the entry at wr_ptr is written; wr_ptr increments.
  - Rejected: overflow_o <= 1; no state changes.
- Simultaneous write and read, same channel, empty: the read is rejected (underflow) and the write is accepted. There is no bypass.
- Simultaneous write and read, different channels: both are evaluated independently.
- Pointer wrap: natural binary rollover; no special case is needed.
- Cycles with neither request: valid_o = 0, overflow_o = 0, underflow_o = 0.
- Storage is not reset; pointers, data_o, rd_vc_o and all flags are reset.

## Timing
- Reset values: data_o = 0, valid_o = 0, rd_vc_o = 0, overflow_o = 0, underflow_o = 0, full_o = 0, empty_o = all ones, count_o = 0.
  - Reset asserted mid-operation empties every channel immediately (asynchronously).
- Read latency: 1 cycle. A read accepted at edge N presents data at edge N (registered), and it is valid for cycle N..N+1.
- full_o, empty_o and count_o are combinational from the pointers. They reflect all accepts of the previous edge.
- Throughput: one write and one read per cycle, sustained, in any channel combination.

## Configuration
- VC_FIFO_ALMOST_EN: when defined, the block adds:
  - parameter ALMOST_FULL_LEVEL (default D-1);
  - parameter ALMOST_EMPTY_LEVEL (default 1);
  - output almost_full_o [VC_NUM]: bit v = count_v >= ALMOST_FULL_LEVEL;
  - output almost_empty_o [VC_NUM]: bit v = count_v <= ALMOST_EMPTY_LEVEL.
  - Both outputs are combinational; at reset almost_full_o = 0 and almost_empty_o = all ones.
- When undefined, those parameters, ports and comparators do not exist. All other behaviour is identical.

## Structure
- Shared package vc_fifo_pkg holds:
  - the clog2 function;
  - VC_ID_WIDTH = max(1, clog2(VC_NUM));
  - the pointer-width rule (FIFO_DEPTH_WIDTH+1).
  - Router VC logic imports the same package.
- Sub-module vc_fifo_bank: one channel's storage array, pointer pair, full/empty/count and optional almost flags. It is instantiated VC_NUM times in a generate loop.
- The top level holds the request decode and accept logic, the output read mux, and the data_o, valid_o, rd_vc_o and pulse-flag registers.

## Test plan
All scenarios use default parameters (D = 4, VC_NUM = 2).
- Reset, then no traffic: empty_o = 2'b11, full_o = 0, count_o = 0, valid_o = 0. Assert rst_ni low mid-burst: the same values appear within the cycle.
- Write 0x11, 0x22, 0x33, 0x44 to VC0 -> full_o[0] = 1, count0 = 4, VC1 is still empty. A fifth write -> overflow_o pulses one cycle and count0 stays 4.
- Fill VC0, then write 0x55 and read VC0 in the same cycle:
  - data_o = 0x11, valid_o = 1, rd_vc_o = 0, no overflow, count0 = 4.
  - Draining VC0 then returns 0x22, 0x33, 0x44, 0x55.
- Interleave writes to VC0 (0xA0..) and VC1 (0xB0..), then read alternately -> each channel returns its own data in order, with rd_vc_o matching. Repeat for 10 fills so the pointers wrap several times.
- Read an empty VC1 while writing 0x77 to VC1 -> underflow_o pulses, valid_o = 0, count1 = 1; the next read returns 0x77.
- VC_FIFO_ALMOST_EN defined with levels 3 and 1:
  - count 0 -> almost_empty_o[0] = 1;
  - count 2 -> both almost flags are 0;
  - count 3 -> almost_full_o[0] = 1.
- With VC_NUM = 3, a write to vc 3 -> overflow_o pulses and no channel's count changes.
